// File: rtl/mips_mem_pkg.sv
// Shared encodings and helpers for the load/store unit: access sizes,
// FSM states and the alignment check.
package mips_mem_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DONE = 2'b10
  } mem_state_t;

  // Reserved size counts as an error so the core raises an exception.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_B:  is_misaligned = 1'b0;
      SIZE_H:  is_misaligned = off[0];
      SIZE_W:  is_misaligned = (off != 2'b00);
      default: is_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: store replication / byte enables and
// load lane selection with sign or zero extension (little-endian lanes).
module mem_lane_align
  import mips_mem_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_wea,
  output logic [31:0] st_din,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_off,
  input  logic        ld_unsigned,
  input  logic [31:0] ld_dout,
  output logic [31:0] ld_data
);

  logic [31:0] dout_shifted;
  logic [15:0] half_sel;

  always_comb begin
    st_wea = 4'b0000;
    st_din = 32'h0;
    case (st_size)
      SIZE_B: begin
        st_wea = 4'b0001 << st_off;
        st_din = {4{st_wdata[7:0]}};
      end
      SIZE_H: begin
        st_wea = st_off[1] ? 4'b1100 : 4'b0011;
        st_din = {2{st_wdata[15:0]}};
      end
      SIZE_W: begin
        st_wea = 4'b1111;
        st_din = st_wdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    dout_shifted = ld_dout >> {ld_off, 3'b000};
    half_sel     = ld_off[1] ? ld_dout[31:16] : ld_dout[15:0];
    case (ld_size)
      SIZE_B:  ld_data = {{24{~ld_unsigned & dout_shifted[7]}}, dout_shifted[7:0]};
      SIZE_H:  ld_data = {{16{~ld_unsigned & half_sel[15]}}, half_sel};
      default: ld_data = ld_dout;
    endcase
  end

endmodule

// File: rtl/data_mem_access.sv
// Load/store unit between the core memory stage and a synchronous-read BRAM.
// Stores finish in the issue cycle; loads stall through WAIT and complete in DONE.
module data_mem_access
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_size,
  input  logic              mem_unsigned,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_stall,
  output logic              addr_err,
  output logic              ram_ena,
  output logic [3:0]        ram_wea,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout
);

  mem_state_t  state_q, state_d;
  logic [1:0]  off_q, off_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] rdata_q, rdata_d;

  logic [3:0]  st_wea;
  logic [31:0] st_din;
  logic [31:0] ld_data;
  logic        ena_c, stall_c, err_c;
  logic [3:0]  wea_c;
  logic        addr_unused;

  // Upper address bits alias onto the BRAM range.
  assign addr_unused = ^mem_addr[31:ADDR_W+2];

  mem_lane_align u_align (
    .st_size    (mem_size),
    .st_off     (mem_addr[1:0]),
    .st_wdata   (mem_wdata),
    .st_wea     (st_wea),
    .st_din     (st_din),
    .ld_size    (size_q),
    .ld_off     (off_q),
    .ld_unsigned(uns_q),
    .ld_dout    (ram_dout),
    .ld_data    (ld_data)
  );

  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    size_d  = size_q;
    uns_d   = uns_q;
    rdata_d = rdata_q;
    ena_c   = 1'b0;
    wea_c   = 4'b0000;
    stall_c = 1'b0;
    err_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_req) begin
          if (is_misaligned(mem_size, mem_addr[1:0])) begin
            err_c = 1'b1;
          end else if (mem_we) begin
            ena_c = 1'b1;
            wea_c = st_wea;
          end else begin
            ena_c   = 1'b1;
            stall_c = 1'b1;
            off_d   = mem_addr[1:0];
            size_d  = mem_size;
            uns_d   = mem_unsigned;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        stall_c = 1'b1;
        rdata_d = ld_data;
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are gated by rst so nothing reaches the BRAM or the core mid-reset.
  always_comb begin
    ram_ena   = ena_c & ~rst;
    ram_wea   = rst ? 4'b0000 : wea_c;
    ram_addr  = ram_ena ? mem_addr[ADDR_W+1:2] : '0;
    ram_din   = (ram_ena && mem_we) ? st_din : 32'h0;
    mem_stall = stall_c & ~rst;
    addr_err  = err_c & ~rst;
    mem_rdata = addr_err ? 32'h0 : rdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      off_q   <= 2'b00;
      size_q  <= SIZE_W;
      uns_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_data_mem_access.sv
// Directed bench for data_mem_access with a behavioural synchronous-read BRAM.
module tb_data_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req, mem_we, mem_unsigned;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_stall, addr_err, ram_ena;
  logic [3:0]  ram_wea;
  logic [9:0]  ram_addr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;

  logic [31:0] bram [0:1023];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_mem_access #(.ADDR_W(10)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we),
    .mem_size(mem_size), .mem_unsigned(mem_unsigned), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_stall(mem_stall),
    .addr_err(addr_err), .ram_ena(ram_ena), .ram_wea(ram_wea),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always @(posedge clk) begin
    if (ram_ena) begin
      for (int i = 0; i < 4; i++)
        if (ram_wea[i]) bram[ram_addr][8*i +: 8] <= ram_din[8*i +: 8];
      ram_dout <= bram[ram_addr];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd);
    mem_req = 1'b1; mem_we = we; mem_size = sz; mem_unsigned = uns;
    mem_addr = addr; mem_wdata = wd;
    #1;
  endtask

  task automatic idle();
    mem_req = 1'b0; mem_we = 1'b0;
    step();
  endtask

  task automatic do_store(input string name, input logic [1:0] sz, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] exp_wea,
                          input logic [31:0] exp_din);
    drive(1'b1, sz, 1'b0, addr, wd);
    checks++;
    if (ram_wea !== exp_wea || ram_din !== exp_din || ram_ena !== 1'b1 ||
        mem_stall !== 1'b0 || ram_addr !== addr[11:2]) begin
      errors++;
      $display("FAIL %s store: wea=%b din=%h ena=%b stall=%b addr=%h, need wea=%b din=%h ena=1 stall=0 addr=%h",
               name, ram_wea, ram_din, ram_ena, mem_stall, ram_addr, exp_wea, exp_din, addr[11:2]);
    end else $display("ok   %s store wea=%b din=%h", name, ram_wea, ram_din);
    step();
  endtask

  // Leaves the request asserted in the following IDLE cycle so the next call is back-to-back.
  task automatic do_load(input string name, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] exp);
    drive(1'b0, sz, uns, addr, 32'h0);
    checks++;
    if (mem_stall !== 1'b1 || ram_ena !== 1'b1 || ram_wea !== 4'b0 || ram_addr !== addr[11:2]) begin
      errors++;
      $display("FAIL %s issue: stall=%b ena=%b wea=%b addr=%h, need 1 1 0000 %h",
               name, mem_stall, ram_ena, ram_wea, ram_addr, addr[11:2]);
    end
    step();
    checks++;
    if (mem_stall !== 1'b1 || ram_ena !== 1'b0 || ram_wea !== 4'b0) begin
      errors++;
      $display("FAIL %s wait: stall=%b ena=%b wea=%b, need 1 0 0000", name, mem_stall, ram_ena, ram_wea);
    end
    step();
    checks++;
    if (mem_stall !== 1'b0 || mem_rdata !== exp || ram_ena !== 1'b0 || ram_wea !== 4'b0) begin
      errors++;
      $display("FAIL %s done: stall=%b rdata=%h ena=%b wea=%b, need 0 %h 0 0000",
               name, mem_stall, mem_rdata, ram_ena, ram_wea, exp);
    end else $display("ok   %s load rdata=%h", name, mem_rdata);
    step();
  endtask

  task automatic do_err(input string name, input logic we, input logic [1:0] sz, input logic [31:0] addr);
    drive(we, sz, 1'b0, addr, 32'hFFFF_FFFF);
    checks++;
    if (addr_err !== 1'b1 || mem_stall !== 1'b0 || ram_ena !== 1'b0 || ram_wea !== 4'b0) begin
      errors++;
      $display("FAIL %s err: addr_err=%b stall=%b ena=%b wea=%b, need 1 0 0 0000",
               name, addr_err, mem_stall, ram_ena, ram_wea);
    end else $display("ok   %s addr_err", name);
    step();
    mem_req = 1'b0;
    #1;
    checks++;
    if (addr_err !== 1'b0) begin
      errors++;
      $display("FAIL %s err_clear: addr_err=%b, need 0", name, addr_err);
    end
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    step(); step();
    checks++;
    if (mem_stall !== 1'b0 || mem_rdata !== 32'h0 || addr_err !== 1'b0 ||
        ram_ena !== 1'b0 || ram_wea !== 4'b0) begin
      errors++;
      $display("FAIL reset: stall=%b rdata=%h err=%b ena=%b wea=%b, need all 0",
               mem_stall, mem_rdata, addr_err, ram_ena, ram_wea);
    end else $display("ok   reset outputs idle");
    mem_req = 1'b0;
    rst = 1'b0;
    step();
  endtask

  task automatic test_word();
    do_store("sw", 2'b10, 32'h10, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF);
    idle();
    do_load("lw", 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    idle();
  endtask

  task automatic test_byte();
    do_store("sb", 2'b00, 32'h13, 32'h0000_0080, 4'b1000, 32'h80808080);
    idle();
    do_load("lb", 2'b00, 1'b0, 32'h13, 32'hFFFFFF80);
    do_load("lbu", 2'b00, 1'b1, 32'h13, 32'h00000080);
    do_load("lbu_l1", 2'b00, 1'b1, 32'h11, 32'h000000BE);
    idle();
  endtask

  task automatic test_half();
    do_store("sh", 2'b01, 32'h16, 32'h0000_8001, 4'b1100, 32'h80018001);
    idle();
    do_load("lh", 2'b01, 1'b0, 32'h16, 32'hFFFF8001);
    do_load("lhu", 2'b01, 1'b1, 32'h16, 32'h00008001);
    idle();
  endtask

  task automatic test_misaligned();
    do_err("lw_02", 1'b0, 2'b10, 32'h02);
    do_err("sh_05", 1'b1, 2'b01, 32'h05);
    do_err("rsvd", 1'b0, 2'b11, 32'h08);
  endtask

  task automatic test_back_to_back();
    do_load("lw_0", 2'b10, 1'b0, 32'h0, 32'h11223344);
    do_load("lw_4", 2'b10, 1'b0, 32'h4, 32'h55667788);
    do_load("alias", 2'b10, 1'b0, 32'h1010, 32'h80ADBEEF);
    idle();
  endtask

  task automatic test_reset_in_wait();
    drive(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    step();
    rst = 1'b1;
    #1;
    checks++;
    if (mem_stall !== 1'b0 || mem_rdata !== 32'h0 || ram_ena !== 1'b0) begin
      errors++;
      $display("FAIL rst_wait: stall=%b rdata=%h ena=%b, need 0 0 0", mem_stall, mem_rdata, ram_ena);
    end else $display("ok   reset in WAIT aborts");
    mem_req = 1'b0;
    step();
    rst = 1'b0;
    step();
    do_load("lw_after_rst", 2'b10, 1'b0, 32'h10, 32'h80ADBEEF);
    idle();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) bram[i] = 32'h0;
    bram[0] = 32'h11223344;
    bram[1] = 32'h55667788;
    ram_dout = 32'h0;
    mem_req = 1'b0; mem_we = 1'b0; mem_size = 2'b10; mem_unsigned = 1'b0;
    mem_addr = 32'h0; mem_wdata = 32'h0;
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_misaligned();
    test_back_to_back();
    test_reset_in_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
